// File: rtl/mips_avalon_pkg.sv
// mips_avalon_pkg: shared types and constants for the MIPS Avalon-MM master
// adapter and its lane-alignment helper.
package mips_avalon_pkg;

    // Access size as presented by the core; value 3 is reserved and rejected.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    // Adapter FSM encoding: IDLE accepts requests, BUS owns the Avalon command.
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t BUS  = 1'b1;

    // Byte-enable patterns for the little-endian lanes.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Avalon addresses are word aligned; the low bits travel as byte enables.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_lane_align.sv
// mips_lane_align: combinational lane steering for the MIPS Avalon master.
// Produces byte enables and replicated store data from size/address, extracts
// and extends load data from the bus word, and flags misaligned or reserved
// accesses.
module mips_lane_align
    import mips_avalon_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Pick the addressed byte and half out of the little-endian bus word.
    always_comb begin
        case (addr)
            2'd0:    lane_byte = readdata[7:0];
            2'd1:    lane_byte = readdata[15:8];
            2'd2:    lane_byte = readdata[23:16];
            default: lane_byte = readdata[31:24];
        endcase
        lane_half = addr[1] ? readdata[31:16] : readdata[15:0];
    end

    // Size-dependent byte enables, store replication, load extension, alignment.
    always_comb begin
        byteenable = BE_NONE;
        writedata  = wdata;
        load_data  = '0;
        misalign   = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byteenable = BE_BYTE0 << addr;
                writedata  = {4{wdata[7:0]}};
                load_data  = {{24{sign_ext & lane_byte[7]}}, lane_byte};
            end
            SIZE_HALF: begin
                byteenable = addr[1] ? BE_HI_HALF : BE_LO_HALF;
                writedata  = {2{wdata[15:0]}};
                load_data  = {{16{sign_ext & lane_half[15]}}, lane_half};
                misalign   = addr[0];
            end
            SIZE_WORD: begin
                byteenable = BE_WORD;
                writedata  = wdata;
                load_data  = readdata;
                misalign   = (addr != 2'b00);
            end
            default: begin
                misalign   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_avalon_master.sv
// mips_avalon_master: converts one MIPS load/store at a time into a single
// word-aligned Avalon-MM read or write, then returns extended load data or a
// store completion. Optional bus timeout is enabled by defining
// MIPS_AVALON_MASTER_TIMEOUT_EN (TIMEOUT_CYCLES stalled edges abort the transfer).
module mips_avalon_master
    import mips_avalon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    state_t      state_q, state_d;
    size_e       size_q, size_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        signed_q, signed_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_write_q, avm_write_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic [3:0]  avm_byteenable_q, avm_byteenable_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        in_idle;
    size_e       la_size;
    logic [1:0]  la_addr;
    logic        la_signed;
    logic [3:0]  la_byteenable;
    logic [31:0] la_writedata;
    logic [31:0] la_load_data;
    logic        la_misalign;
    logic        timeout_hit;

    assign in_idle = (state_q == IDLE);

    // The single aligner sees the live request while idle (to build the
    // command) and the captured request while on the bus (to extract load data).
    assign la_size   = in_idle ? size_e'(req_size) : size_q;
    assign la_addr   = in_idle ? req_addr[1:0]     : addr_lo_q;
    assign la_signed = in_idle ? req_signed        : signed_q;

    mips_lane_align u_lane_align (
        .size       (la_size),
        .addr       (la_addr),
        .sign_ext   (la_signed),
        .wdata      (req_wdata),
        .readdata   (avm_readdata),
        .byteenable (la_byteenable),
        .writedata  (la_writedata),
        .load_data  (la_load_data),
        .misalign   (la_misalign)
    );

`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    assign timeout_hit = avm_waitrequest && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled edges in BUS; idle holds the counter at zero.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (in_idle) begin
            to_cnt_d = '0;
        end else if (avm_waitrequest) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Request acceptance, bus command hold, and completion/response generation.
    always_comb begin
        state_d          = state_q;
        size_d           = size_q;
        addr_lo_d        = addr_lo_q;
        signed_d         = signed_q;
        avm_address_d    = avm_address_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;
        resp_valid_d     = 1'b0;
        resp_err_d       = 1'b0;
        resp_rdata_d     = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (la_misalign) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d          = BUS;
                        size_d           = size_e'(req_size);
                        addr_lo_d        = req_addr[1:0];
                        signed_d         = req_signed;
                        avm_address_d    = word_align(req_addr);
                        avm_read_d       = !req_write;
                        avm_write_d      = req_write;
                        avm_writedata_d  = la_writedata;
                        avm_byteenable_d = la_byteenable;
                    end
                end
            end
            default: begin
                if (!avm_waitrequest || timeout_hit) begin
                    state_d          = IDLE;
                    avm_address_d    = '0;
                    avm_read_d       = 1'b0;
                    avm_write_d      = 1'b0;
                    avm_writedata_d  = '0;
                    avm_byteenable_d = BE_NONE;
                    resp_valid_d     = 1'b1;
                    resp_err_d       = timeout_hit;
                    resp_rdata_d     = (avm_read_q && !timeout_hit) ? la_load_data : '0;
                end
            end
        endcase
    end

    // State, captured request and registered bus/response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            size_q           <= SIZE_BYTE;
            addr_lo_q        <= 2'b00;
            signed_q         <= 1'b0;
            avm_address_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= BE_NONE;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
        end else begin
            state_q          <= state_d;
            size_q           <= size_d;
            addr_lo_q        <= addr_lo_d;
            signed_q         <= signed_d;
            avm_address_q    <= avm_address_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
        end
    end

    assign req_ready      = in_idle;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;

endmodule

// File: doc/mips_avalon_master.md
# mips_avalon_master

CPU-side Avalon-MM master adapter: accepts one load/store request at a time from the MIPS core (byte, halfword or word, signed or unsigned) and converts it into a single word-aligned Avalon read or write with byte enables. It holds the bus command stable until waitrequest drops. It then returns lane-extracted, sign- or zero-extended load data, or a store completion, to the core. It sits directly upstream of the Avalon memory slave (`mips_avalon_slave`) and drives its address/read/write/writedata/byteenable inputs.

## Interface
- TIMEOUT_CYCLES, 256: bus-cycle limit per transfer; used only with the timeout feature.
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  core request present
- req_ready  out  1  adapter can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error)
- req_signed  in  1  sign-extend load data (ignored for word and store)
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, reserved size, or timeout; valid with resp_valid
- avm_address  out  32  {req_addr[31:2], 2'b00}
- avm_read, avm_write  out  1  Avalon commands, mutually exclusive
- avm_writedata  out  32  lane-replicated store data
- avm_byteenable  out  4  active lanes
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data

## Operation
- States: IDLE, BUS. Request, address, size and data are registered at acceptance.
- IDLE: req_ready = 1. On req_valid:
  - Misaligned request (half with addr[0] = 1, word with addr[1:0] != 0) or size 3: no bus cycle; stay in IDLE; next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0.
  - Otherwise: go to BUS.
- BUS:
  - avm_read or avm_write = 1, with all avm_* outputs driven from registers and stable.
  - Completion edge: rising edge with avm_waitrequest = 0. At that edge, capture readdata, drop the command, return to IDLE, and pulse resp_valid next cycle.
- Lane mapping is little-endian: lane k = bits [8k+7:8k], selected by addr[1:0].
  - Byte: byteenable = 1 << addr[1:0]; writedata = {4{wdata[7:0]}}.
  - Half: byteenable = 4'b0011 or 4'b1100 (addr[1] = 0 or 1); writedata = {2{wdata[15:0]}}.
  - Word: byteenable = 4'b1111; writedata = wdata.
- Load extraction: select the lane(s) by the registered addr[1:0]. Extend to 32 bits: sign-extend if req_signed, else zero-extend.
- When idle, all avm_* outputs are 0.
- A new request can be accepted in the same cycle that resp_valid is high.
- Reset: asynchronous. Forces IDLE, drops avm_read and avm_write immediately, and clears resp_valid, resp_err and resp_rdata. An in-flight transfer is abandoned with no response.

## Timing
- Reset values: req_ready = 1; resp_valid = 0; resp_err = 0; resp_rdata = 0; all avm_* = 0.
- Bus command asserts the cycle after acceptance.
- Latency from acceptance edge to resp_valid high = 2 + N cycles, where N = number of waitrequest-high edges seen in BUS.
- Error response without a bus cycle: resp_valid one cycle after acceptance.
- Command held continuously from BUS entry to the completion edge; no mid-transfer changes.

## Configuration
- MIPS_AVALON_MASTER_TIMEOUT_EN defined:
  - A counter starts at BUS entry.
  - If TIMEOUT_CYCLES consecutive edges have waitrequest = 1, the command is dropped and the state returns to IDLE.
  - resp_valid = 1, resp_err = 1, resp_rdata = 0 on the next cycle.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; BUS waits indefinitely; resp_err arises only from alignment or size errors.

## Structure
- Package mips_avalon_pkg:
  - size enum: SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2.
  - state enum: IDLE, BUS.
  - Byte-enable constants.
- Sub-module mips_lane_align, combinational:
  - Inputs: size, addr[1:0], signed, wdata, readdata.
  - Outputs: byteenable, replicated writedata, extended load data, misalign flag.
  - Instantiated once; the top holds the FSM, registers and optional timeout.

## Test plan
- Word store 0xDEADBEEF to 0xBFC00010, slave WRITE_DELAY = 2 → avm_write held until waitrequest = 0; byteenable = 4'hF; single resp_valid with resp_err = 0; a later word load returns 0xDEADBEEF.
- Byte load, signed, 0xBFC00013, memory word 0x80FF7F01 → byteenable = 4'b1000; resp_rdata = 0xFFFFFF80. Same load unsigned → 0x00000080.
- Half store 0x1234 to 0xBFC00022 over word 0xAAAAAAAA → byteenable = 4'b1100; writedata = 0x12341234; memory becomes 0x1234AAAA.
- Half load at 0xBFC00001 → no avm_read ever asserted; resp_valid next cycle with resp_err = 1 and resp_rdata = 0.
- rst pulled low while in BUS with avm_read high → avm_read = 0 immediately; no resp_valid; after release, req_ready = 1 and a new load completes normally.
- With MIPS_AVALON_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 8, waitrequest tied high → command drops after 8 edges; resp_err = 1. Without the macro, avm_read stays high for 1000 cycles.
